// File: rtl/fetch_ctrl_if.sv
// Fetch-control bundle: decode/execute events in, fetch redirect and stall controls out.
// master = pipeline side driving events, slave = fetch_ctrl_fsm.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] pc_current;
  logic              dec_valid;
  logic              dec_jmp;
  logic              dec_call;
  logic              dec_ret;
  logic              dec_halt;
  logic [ADDR_W-1:0] dec_target;
  logic              ex_br_taken;
  logic [ADDR_W-1:0] ex_br_target;
  logic              load_use;
  logic              resume;
  logic              pc_mux_sel;
  logic [ADDR_W-1:0] jmp_loc;
  logic              Stall;
  logic              Stall_pm;
  logic              flush;
  logic              halted;
  logic              ras_ovf;
  logic              ras_unf;

  modport master (
    output pc_current, dec_valid, dec_jmp, dec_call, dec_ret, dec_halt, dec_target,
           ex_br_taken, ex_br_target, load_use, resume,
    input  pc_mux_sel, jmp_loc, Stall, Stall_pm, flush, halted, ras_ovf, ras_unf
  );

  modport slave (
    input  pc_current, dec_valid, dec_jmp, dec_call, dec_ret, dec_halt, dec_target,
           ex_br_taken, ex_br_target, load_use, resume,
    output pc_mux_sel, jmp_loc, Stall, Stall_pm, flush, halted, ras_ovf, ras_unf
  );
endinterface

// File: rtl/fetch_ctrl_fsm.sv
// Fetch sequencer: redirect/stall are combinational in the event cycle, flush/halted/RAS flags one cycle later.
// Load-use holds fetch for LOAD_STALL cycles; halt holds it until resume; taken branches always win.
module fetch_ctrl_fsm #(
  parameter int ADDR_W     = 8,
  parameter int RAS_DEPTH  = 4,
  parameter int LOAD_STALL = 1
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [2:0]     STALL_INIT = 3'(LOAD_STALL - 1);
  localparam logic [PTR_W:0] RAS_FULL   = (PTR_W + 1)'(RAS_DEPTH);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              halt_first;
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W:0]    ras_cnt;
  logic              flush_q, halted_q, ovf_q, unf_q;

  logic              dec_ev, redirect, stall, go_stall;
  logic              do_push, do_pop, do_halt, do_unf;
  logic [ADDR_W-1:0] target;
  logic [PTR_W-1:0]  pop_ptr;

  always_comb begin
    dec_ev   = bus.dec_valid & ~flush_q;
    pop_ptr  = ptr - 1'b1;
    redirect = 1'b0;
    target   = '0;
    stall    = 1'b0;
    go_stall = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_halt  = 1'b0;
    do_unf   = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.ex_br_taken) begin
          redirect = 1'b1;
          target   = bus.ex_br_target;
        end else if (bus.load_use) begin
          stall    = 1'b1;
          go_stall = (LOAD_STALL > 1);
        end else if (dec_ev) begin
          if (bus.dec_ret) begin
            if (ras_cnt != '0) begin
              redirect = 1'b1;
              target   = ras[pop_ptr];
              do_pop   = 1'b1;
            end else begin
              do_unf  = 1'b1;
              do_halt = 1'b1;
            end
          end else if (bus.dec_call) begin
            redirect = 1'b1;
            target   = bus.dec_target;
            do_push  = 1'b1;
          end else if (bus.dec_jmp) begin
            redirect = 1'b1;
            target   = bus.dec_target;
          end else if (bus.dec_halt) begin
            do_halt = 1'b1;
          end
        end
      end
      STALL: begin
        // A taken branch cancels the remaining stall so the redirect can load.
        if (bus.ex_br_taken) begin
          redirect = 1'b1;
          target   = bus.ex_br_target;
        end else begin
          stall = 1'b1;
        end
      end
      HALT: begin
        stall = 1'b1;
        if (halt_first && bus.ex_br_taken) begin
          redirect = 1'b1;
          target   = bus.ex_br_target;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc_mux_sel = reset & redirect;
  assign bus.jmp_loc    = reset ? target : '0;
  assign bus.Stall      = reset & stall;
  assign bus.Stall_pm   = reset & stall;
  assign bus.flush      = flush_q;
  assign bus.halted     = halted_q;
  assign bus.ras_ovf    = ovf_q;
  assign bus.ras_unf    = unf_q;

  // Entries are never reset; ras_cnt=0 marks them all invalid.
  always_ff @(posedge clk) begin
    if (do_push) ras[ptr] <= bus.pc_current + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      cnt        <= '0;
      halt_first <= 1'b0;
      ptr        <= '0;
      ras_cnt    <= '0;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      flush_q    <= redirect;
      halt_first <= 1'b0;
      unique case (state)
        RUN: begin
          if (go_stall) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end else if (do_halt) begin
            state      <= HALT;
            halted_q   <= 1'b1;
            halt_first <= 1'b1;
          end
        end
        STALL: begin
          if (redirect) begin
            state <= RUN;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt <= 3'd1) state <= RUN;
          end
        end
        HALT: begin
          if (bus.resume) begin
            state    <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
      // Full stack wraps onto its oldest entry.
      if (do_push) begin
        ptr <= ptr + 1'b1;
        if (ras_cnt == RAS_FULL) ovf_q <= 1'b1;
        else                     ras_cnt <= ras_cnt + 1'b1;
      end
      if (do_pop) begin
        ptr     <= pop_ptr;
        ras_cnt <= ras_cnt - 1'b1;
      end
      if (do_unf) unf_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl_fsm.sv
// Directed bench for fetch_ctrl_fsm (RAS_DEPTH=4, LOAD_STALL=3).
module tb_fetch_ctrl_fsm;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(8)) bus ();

  fetch_ctrl_fsm #(.ADDR_W(8), .RAS_DEPTH(4), .LOAD_STALL(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.pc_current   = 8'h00;
    bus.dec_valid    = 1'b0;
    bus.dec_jmp      = 1'b0;
    bus.dec_call     = 1'b0;
    bus.dec_ret      = 1'b0;
    bus.dec_halt     = 1'b0;
    bus.dec_target   = 8'h00;
    bus.ex_br_taken  = 1'b0;
    bus.ex_br_target = 8'h00;
    bus.load_use     = 1'b0;
    bus.resume       = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pc_mux_sel"}, 32'(bus.pc_mux_sel), 32'd0);
    chk({tag, ".jmp_loc"},    32'(bus.jmp_loc),    32'd0);
    chk({tag, ".Stall"},      32'(bus.Stall),      32'd0);
    chk({tag, ".Stall_pm"},   32'(bus.Stall_pm),   32'd0);
    chk({tag, ".flush"},      32'(bus.flush),      32'd0);
    chk({tag, ".halted"},     32'(bus.halted),     32'd0);
    chk({tag, ".ras_ovf"},    32'(bus.ras_ovf),    32'd0);
    chk({tag, ".ras_unf"},    32'(bus.ras_unf),    32'd0);
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    repeat (2) cyc();
    chk_all_zero("reset");
    reset = 1'b1;
    cyc();

    // T2: call then return
    bus.dec_valid = 1'b1; bus.dec_call = 1'b1; bus.pc_current = 8'h10; bus.dec_target = 8'h40;
    #1;
    chk("t2.call.sel", 32'(bus.pc_mux_sel), 32'd1);
    chk("t2.call.loc", 32'(bus.jmp_loc), 32'h40);
    cyc();
    clear_in();
    bus.dec_valid = 1'b1; bus.dec_jmp = 1'b1; bus.dec_target = 8'h77;
    #1;
    chk("t2.call.flush", 32'(bus.flush), 32'd1);
    chk("t2.flushed_jmp_ignored", 32'(bus.pc_mux_sel), 32'd0);
    cyc();
    clear_in();
    chk("t2.flush_pulse", 32'(bus.flush), 32'd0);
    bus.dec_valid = 1'b1; bus.dec_ret = 1'b1;
    #1;
    chk("t2.ret.sel", 32'(bus.pc_mux_sel), 32'd1);
    chk("t2.ret.loc", 32'(bus.jmp_loc), 32'h11);
    cyc();
    clear_in();
    chk("t2.ret.flush", 32'(bus.flush), 32'd1);
    cyc();

    // T3: overflow then underflow of the 4-entry RAS
    for (int i = 0; i < 5; i++) begin
      bus.dec_valid = 1'b1; bus.dec_call = 1'b1;
      bus.pc_current = 8'(8'h20 + i); bus.dec_target = 8'(8'h50 + i);
      #1;
      chk("t3.call.loc", 32'(bus.jmp_loc), 32'(8'h50 + i));
      cyc();
      clear_in();
      chk("t3.ovf", 32'(bus.ras_ovf), 32'(i == 4));
      cyc();
    end
    for (int j = 0; j < 4; j++) begin
      bus.dec_valid = 1'b1; bus.dec_ret = 1'b1;
      #1;
      chk("t3.ret.sel", 32'(bus.pc_mux_sel), 32'd1);
      chk("t3.ret.loc", 32'(bus.jmp_loc), 32'(8'h25 - j));
      cyc();
      clear_in();
      cyc();
    end
    bus.dec_valid = 1'b1; bus.dec_ret = 1'b1;
    #1;
    chk("t3.unf.no_redirect", 32'(bus.pc_mux_sel), 32'd0);
    cyc();
    clear_in();
    chk("t3.unf", 32'(bus.ras_unf), 32'd1);
    chk("t3.unf.halted", 32'(bus.halted), 32'd1);
    chk("t3.ovf.sticky", 32'(bus.ras_ovf), 32'd1);
    #1;
    chk("t3.unf.stall", 32'(bus.Stall), 32'd1);
    bus.resume = 1'b1;
    cyc();
    clear_in();
    chk("t3.resume", 32'(bus.halted), 32'd0);

    // T4: branch beats load_use and decode jump
    bus.ex_br_taken = 1'b1; bus.ex_br_target = 8'h22;
    bus.dec_valid = 1'b1; bus.dec_jmp = 1'b1; bus.dec_target = 8'h80;
    bus.load_use = 1'b1;
    #1;
    chk("t4.sel", 32'(bus.pc_mux_sel), 32'd1);
    chk("t4.loc", 32'(bus.jmp_loc), 32'h22);
    chk("t4.no_stall", 32'(bus.Stall), 32'd0);
    cyc();
    clear_in();
    chk("t4.flush", 32'(bus.flush), 32'd1);
    #1;
    chk("t4.no_stall_after", 32'(bus.Stall), 32'd0);
    cyc();

    // T5: 3-cycle load-use stall, pending jump then executes
    bus.load_use = 1'b1; bus.dec_valid = 1'b1; bus.dec_jmp = 1'b1; bus.dec_target = 8'h90;
    #1;
    chk("t5.c0.stall", 32'(bus.Stall), 32'd1);
    chk("t5.c0.stall_pm", 32'(bus.Stall_pm), 32'd1);
    chk("t5.c0.sel", 32'(bus.pc_mux_sel), 32'd0);
    cyc();
    bus.load_use = 1'b0;
    #1;
    chk("t5.c1.stall", 32'(bus.Stall), 32'd1);
    chk("t5.c1.sel", 32'(bus.pc_mux_sel), 32'd0);
    cyc();
    #1;
    chk("t5.c2.stall_pm", 32'(bus.Stall_pm), 32'd1);
    cyc();
    #1;
    chk("t5.c3.stall", 32'(bus.Stall), 32'd0);
    chk("t5.c3.sel", 32'(bus.pc_mux_sel), 32'd1);
    chk("t5.c3.loc", 32'(bus.jmp_loc), 32'h90);
    cyc();
    clear_in();
    chk("t5.flush", 32'(bus.flush), 32'd1);
    cyc();

    // T6: halt ignores decode for 20 cycles until resume
    bus.dec_valid = 1'b1; bus.dec_halt = 1'b1;
    #1;
    chk("t6.halt.sel", 32'(bus.pc_mux_sel), 32'd0);
    cyc();
    clear_in();
    chk("t6.halted", 32'(bus.halted), 32'd1);
    for (int k = 0; k < 20; k++) begin
      bus.dec_valid = 1'b1; bus.dec_jmp = 1'b1; bus.dec_target = 8'h33;
      bus.load_use = k[0];
      #1;
      chk("t6.hold.stall", 32'(bus.Stall), 32'd1);
      chk("t6.hold.sel", 32'(bus.pc_mux_sel), 32'd0);
      cyc();
      chk("t6.hold.halted", 32'(bus.halted), 32'd1);
    end
    clear_in();
    bus.resume = 1'b1;
    cyc();
    clear_in();
    chk("t6.resume.halted", 32'(bus.halted), 32'd0);
    #1;
    chk("t6.resume.stall", 32'(bus.Stall), 32'd0);
    cyc();

    // Branch aborts a load-use stall
    bus.load_use = 1'b1;
    cyc();
    bus.load_use = 1'b0; bus.ex_br_taken = 1'b1; bus.ex_br_target = 8'h44;
    #1;
    chk("abort.sel", 32'(bus.pc_mux_sel), 32'd1);
    chk("abort.loc", 32'(bus.jmp_loc), 32'h44);
    cyc();
    clear_in();
    chk("abort.flush", 32'(bus.flush), 32'd1);
    #1;
    chk("abort.run", 32'(bus.Stall), 32'd0);
    cyc();

    // T1: reset in the middle of a stall
    bus.load_use = 1'b1;
    cyc();
    bus.load_use = 1'b0;
    #1;
    chk("t1.in_stall", 32'(bus.Stall), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("t1.async");
    cyc();
    reset = 1'b1;
    #1;
    chk("t1.release.stall", 32'(bus.Stall), 32'd0);
    cyc();
    chk("t1.run.stall", 32'(bus.Stall), 32'd0);
    chk("t1.run.halted", 32'(bus.halted), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
